// File: rtl/ibus_prefetch.sv
// rtl/ibus_prefetch.sv - sequential instruction prefetcher with flush-aware FIFO
// Purpose: sole master of the instruction bus. Fetches sequential words from a
//   running PC into a DEPTH-entry FIFO that the core pops; flush redirects.
// Ports: clk, rst (sync, active high)
//   flush / flush_addr                          redirect, empties FIFO
//   out_valid / out_ready / out_instr / out_pc / out_fault   FIFO head
//   m_req / m_addr / m_w_rb / m_acc / m_wdata   request side (read-only)
//   m_resp / m_rdata / bus_fault                completion side
// Option macro IBUS_PF_PERF_EN: adds perf_fetch_cnt / perf_drop_cnt outputs.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif
`ifndef ROM_BASE
`define ROM_BASE 32'h0000_1000
`endif

module ibus_prefetch #(
    parameter logic [`XLEN-1:0] RESET_PC = `ROM_BASE,
    parameter int unsigned      DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [`XLEN-1:0]                 flush_addr,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [`BUS_WIDTH-1:0]            out_instr,
    output logic [`XLEN-1:0]                 out_pc,
    output logic                             out_fault,
    output logic                             m_req,
    output logic [`XLEN-1:0]                 m_addr,
    output logic                             m_w_rb,
    output logic [$clog2(`BUS_ACC_CNT)-1:0]  m_acc,
    output logic [`BUS_WIDTH-1:0]            m_wdata,
    input  logic                             m_resp,
    input  logic [`BUS_WIDTH-1:0]            m_rdata,
    input  logic                             bus_fault
`ifdef IBUS_PF_PERF_EN
    ,
    output logic [31:0]                      perf_fetch_cnt,
    output logic [31:0]                      perf_drop_cnt
`endif
);
    localparam int XW = `XLEN;
    localparam int DW = `BUS_WIDTH;
    localparam int AW = $clog2(`BUS_ACC_CNT);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HALT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   pc_q, pc_d;      // address of the transfer in flight / next fetch
    logic [XW-1:0]   tgt_q, tgt_d;    // redirect target parked while draining
    logic            req_q, req_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [XW-1:0]   pc_mem    [DEPTH];
    logic [DW-1:0]   instr_mem [DEPTH];
    logic [DEPTH-1:0] fault_mem_q;

    logic            done, push, push_fault, pop, clr, fetched, dropped;
    logic [XW-1:0]   flush_tgt;

    assign flush_tgt = flush_addr & ~XW'(3);

    assign m_req     = req_q;
    assign m_addr    = pc_q;
    assign m_w_rb    = 1'b0;
    assign m_acc     = AW'(2);
    assign m_wdata   = '0;

    assign out_valid = (cnt_q != '0);
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_instr = instr_mem[rd_ptr_q];
    // Storage is not reset; gate the marker so an empty FIFO never shows a fault.
    assign out_fault = out_valid & fault_mem_q[rd_ptr_q];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        req_d      = req_q;
        push       = 1'b0;
        push_fault = 1'b0;
        clr        = 1'b0;
        fetched    = 1'b0;
        dropped    = 1'b0;
        done       = req_q & (m_resp | bus_fault);
        pop        = out_valid & out_ready & ~flush;

        if (flush) begin
            clr     = 1'b1;
            dropped = req_q & m_resp;
            if (req_q && !done) begin
                // Transfer still open: keep the bus request intact, park the target.
                state_d = S_DRAIN;
                tgt_d   = flush_tgt;
            end else begin
                // FIFO is emptied this cycle, so space for the next fetch is guaranteed.
                state_d = S_FETCH;
                pc_d    = flush_tgt;
                req_d   = 1'b1;
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (done) begin
                        push = 1'b1;
                        if (bus_fault) begin
                            push_fault = 1'b1;
                            state_d    = S_HALT;
                        end else begin
                            fetched = 1'b1;
                            pc_d    = pc_q + XW'(4);
                        end
                    end
                end
                S_DRAIN: begin
                    if (done) begin
                        dropped = m_resp;
                        state_d = S_FETCH;
                        pc_d    = tgt_q;
                    end
                end
                default: begin
                end
            endcase
        end

        if (clr) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end

        // Only one response can land per request, so a slot free now is free at response.
        if (!flush) begin
            if (state_d == S_HALT) begin
                req_d = 1'b0;
            end else if (state_d == S_FETCH && (!req_q || done)) begin
                req_d = (cnt_d < DEPTH_C);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            tgt_q    <= RESET_PC;
            req_q    <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            if (clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]      <= pc_q;
            instr_mem[wr_ptr_q]   <= push_fault ? '0 : m_rdata;
            fault_mem_q[wr_ptr_q] <= push_fault;
        end
    end

`ifdef IBUS_PF_PERF_EN
    logic [31:0] fetch_cnt_q, drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (fetched && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (dropped && drop_cnt_q != 32'hFFFF_FFFF)  drop_cnt_q  <= drop_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_drop_cnt  = drop_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = fetched ^ dropped;
`endif

endmodule

// File: tb/tb_ibus_prefetch.sv
// tb/tb_ibus_prefetch.sv - self-checking bench for ibus_prefetch
module tb_ibus_prefetch;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] flush_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_w_rb;
    logic [1:0]  m_acc;
    logic [31:0] m_wdata;
    logic        m_resp;
    logic [31:0] m_rdata;
    logic        bus_fault;
`ifdef IBUS_PF_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    ibus_prefetch #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_addr(flush_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_fault(out_fault),
        .m_req(m_req), .m_addr(m_addr), .m_w_rb(m_w_rb), .m_acc(m_acc),
        .m_wdata(m_wdata), .m_resp(m_resp), .m_rdata(m_rdata), .bus_fault(bus_fault)
`ifdef IBUS_PF_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int lat   = 0;
    int n_done = 0;
    logic [31:0] addr_log [$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    function automatic logic is_fault(input logic [31:0] a);
        return a[31:28] == 4'h5;
    endfunction

    task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Waits for a head entry, checks it against the memory model, and leaves
    // out_ready high so it is consumed at the next edge.
    task automatic pop_expect(input logic [31:0] pc, input logic f, input string nm);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            if (out_valid) begin
                chk_eq({nm, ".pc"}, out_pc, pc);
                chk_eq({nm, ".fault"}, {31'd0, out_fault}, {31'd0, f});
                chk_eq({nm, ".instr"}, out_instr, f ? 32'd0 : memf(pc));
                out_ready = 1'b1;
                got = 1'b1;
            end else begin
                out_ready = 1'b0;
            end
        end
        if (!got) chk_eq({nm, ".timeout"}, 32'd0, 32'd1);
    endtask

    task automatic release_pop();
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk_eq("rst.valid", {31'd0, out_valid}, 0);
        chk_eq("rst.req",   {31'd0, m_req}, 0);
        chk_eq("rst.fault", {31'd0, out_fault}, 0);
        chk_eq("rst.addr",  m_addr, RESET_PC);
        chk_eq("rst.consts", {m_w_rb, m_acc, 29'd0} | m_wdata, {1'b0, 2'b10, 29'd0});
        rst = 1'b0;
    endtask

    // Bus slave: fixed word memory, fault region 0x5xxx_xxxx, response latency lat.
    initial begin : slave
        logic pend;
        logic [31:0] held;
        int scnt;
        pend = 1'b0; held = '0; scnt = 0;
        m_resp = 1'b0; bus_fault = 1'b0; m_rdata = '0;
        forever begin
            @(negedge clk);
            m_resp = 1'b0; bus_fault = 1'b0; m_rdata = '0;
            if (rst) begin
                pend = 1'b0; scnt = 0;
            end else begin
                if (pend) begin
                    chk_eq("bus.req_hold", {31'd0, m_req}, 1);
                    chk_eq("bus.addr_hold", m_addr, held);
                end
                if (m_req) begin
                    if (!pend) begin
                        pend = 1'b1; held = m_addr; scnt = 0;
                        addr_log.push_back(m_addr);
                        chk_eq("bus.align", {30'd0, m_addr[1:0]}, 0);
                    end
                    if (is_fault(m_addr)) begin
                        bus_fault = 1'b1; pend = 1'b0; n_done++;
                    end else if (scnt >= lat) begin
                        m_resp = 1'b1; m_rdata = memf(m_addr); pend = 1'b0; n_done++;
                    end else begin
                        scnt++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] faddr;
        int          lt;
        logic [31:0] pc0;
        logic        f0;
        logic [31:0] pc1;
        logic        f1;
        logic        has1;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int base;
        int dbase;
        int pops;
        logic fseen;
        logic chk_clr;
        logic [31:0] exp_pc;

        tbl[0] = '{32'h0000_1003, 0, 32'h0000_1000, 1'b0, 32'h0000_1004, 1'b0, 1'b1};
        tbl[1] = '{32'h0000_2002, 2, 32'h0000_2000, 1'b0, 32'h0000_2004, 1'b0, 1'b1};
        tbl[2] = '{32'h5000_0001, 0, 32'h5000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        tbl[3] = '{32'hFFFF_FFFD, 1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        tbl[4] = '{32'h0000_0000, 3, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b0, 1'b1};
        tbl[5] = '{32'h4FFF_FFFC, 0, 32'h4FFF_FFFC, 1'b0, 32'h5000_0000, 1'b1, 1'b1};

        rst = 1'b1; flush = 1'b0; flush_addr = '0; out_ready = 1'b0;

        // Sequential stream from RESET_PC, one-cycle slave.
        lat = 0;
        do_reset();
        base = addr_log.size();
        for (int i = 0; i < 8; i++) pop_expect(RESET_PC + 32'(4 * i), 1'b0, "seq");
        release_pop();
        for (int i = 0; i < 8; i++) chk_eq("seq.addr", addr_log[base + i], RESET_PC + 32'(4 * i));

        // Backpressure: exactly DEPTH fetches, then one more per pop.
        lat = 1;
        do_reset();
        dbase = n_done;
        repeat (30) step();
        chk_eq("full.done", 32'(n_done - dbase), 4);
        chk_eq("full.req", {31'd0, m_req}, 0);
        pop_expect(RESET_PC, 1'b0, "full.pop");
        release_pop();
        repeat (20) step();
        chk_eq("full.done2", 32'(n_done - dbase), 5);
        chk_eq("full.req2", {31'd0, m_req}, 0);
        for (int i = 1; i < 5; i++) pop_expect(RESET_PC + 32'(4 * i), 1'b0, "full.rest");
        release_pop();

        // Flush while a transfer is stalled: drain, drop, refetch aligned target.
        lat = 1000;
        do_reset();
        base = addr_log.size();
        for (int i = 0; i < 10 && !m_req; i++) step();
        chk_eq("drain.req", {31'd0, m_req}, 1);
        repeat (3) step();
        flush = 1'b1; flush_addr = 32'h0000_1003;
        step();
        flush = 1'b0;
        chk_eq("drain.valid", {31'd0, out_valid}, 0);
        chk_eq("drain.req_held", {31'd0, m_req}, 1);
        chk_eq("drain.addr_held", m_addr, RESET_PC);
        repeat (2) step();
        lat = 0;
        pop_expect(32'h0000_1000, 1'b0, "drain.first");
        release_pop();
        chk_eq("drain.log0", addr_log[base], RESET_PC);
        chk_eq("drain.log1", addr_log[base + 1], 32'h0000_1000);
`ifdef IBUS_PF_PERF_EN
        chk_eq("drain.perf_drop", perf_drop_cnt, 1);
`endif

        // Flush in the same cycle as the response: no drain, word not pushed.
        lat = 2;
        do_reset();
        for (int i = 0; i < 20 && !m_resp; i++) step();
        chk_eq("same.resp", {31'd0, m_resp}, 1);
        flush = 1'b1; flush_addr = 32'h0000_2000;
        step();
        flush = 1'b0;
        chk_eq("same.valid", {31'd0, out_valid}, 0);
        chk_eq("same.addr", m_addr, 32'h0000_2000);
        pop_expect(32'h0000_2000, 1'b0, "same.first");
        release_pop();

        // Bus fault: marker entry, then no requests until flush.
        lat = 0;
        flush = 1'b1; flush_addr = 32'h4FFF_FFF8;
        step();
        flush = 1'b0;
        pop_expect(32'h4FFF_FFF8, 1'b0, "bf.w0");
        pop_expect(32'h4FFF_FFFC, 1'b0, "bf.w1");
        pop_expect(32'h5000_0000, 1'b1, "bf.fault");
        release_pop();
        for (int i = 0; i < 10; i++) begin
            step();
            chk_eq("bf.halt_req", {31'd0, m_req}, 0);
            chk_eq("bf.halt_valid", {31'd0, out_valid}, 0);
        end
        flush = 1'b1; flush_addr = 32'h0000_3000;
        step();
        flush = 1'b0;
        pop_expect(32'h0000_3000, 1'b0, "bf.resume");
        release_pop();

        // Reset mid-transfer with a nearly full FIFO.
        lat = 0;
        do_reset();
        repeat (20) step();
        chk_eq("rstmid.full_req", {31'd0, m_req}, 0);
        lat = 1000;
        pop_expect(RESET_PC, 1'b0, "rstmid.pop");
        release_pop();
        for (int i = 0; i < 20 && !m_req; i++) step();
        step();
        chk_eq("rstmid.pending", {31'd0, m_req}, 1);
        rst = 1'b1;
        step();
        chk_eq("rstmid.valid", {31'd0, out_valid}, 0);
        chk_eq("rstmid.req", {31'd0, m_req}, 0);
        rst = 1'b0;
        lat = 0;
        base = addr_log.size();
        pop_expect(RESET_PC, 1'b0, "rstmid.first");
        release_pop();
        chk_eq("rstmid.addr", addr_log[base], RESET_PC);

        // Table of redirect targets: alignment, fault, wrap, varied latency.
        for (int i = 0; i < 6; i++) begin
            lat = tbl[i].lt;
            flush = 1'b1; flush_addr = tbl[i].faddr;
            step();
            flush = 1'b0;
            chk_eq("tbl.clr", {31'd0, out_valid}, 0);
            pop_expect(tbl[i].pc0, tbl[i].f0, "tbl.e0");
            if (tbl[i].has1) pop_expect(tbl[i].pc1, tbl[i].f1, "tbl.e1");
            release_pop();
        end

        // Random traffic against a stream model: after a redirect the core must see
        // consecutive words from the aligned target until a fault marker ends the run.
        pops = 0;
        fseen = 1'b0;
        flush = 1'b1; flush_addr = 32'h0000_0100; exp_pc = 32'h0000_0100;
        chk_clr = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (chk_clr) chk_eq("rnd.clr", {31'd0, out_valid}, 0);
            chk_clr = 1'b0;
            if (fseen) chk_eq("rnd.after_fault", {31'd0, out_valid}, 0);
            if ($urandom_range(0, 7) == 0) lat = $urandom_range(0, 3);
            if ($urandom_range(0, 49) == 0) begin
                flush = 1'b1;
                case ($urandom_range(0, 3))
                    0: flush_addr = 32'h0000_0100 + 32'($urandom_range(0, 255));
                    1: flush_addr = 32'h4FFF_FFE0 | 32'($urandom_range(0, 31));
                    2: flush_addr = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
                    default: flush_addr = $urandom & 32'h0FFF_FFFF;
                endcase
                exp_pc = flush_addr & 32'hFFFF_FFFC;
                fseen = 1'b0;
                chk_clr = 1'b1;
                out_ready = ($urandom_range(0, 1) == 1);
            end else begin
                flush = 1'b0;
                out_ready = ($urandom_range(0, 9) < 7);
                if (!fseen && out_valid && out_ready) begin
                    chk_eq("rnd.pc", out_pc, exp_pc);
                    chk_eq("rnd.fault", {31'd0, out_fault}, {31'd0, is_fault(exp_pc)});
                    chk_eq("rnd.instr", out_instr, is_fault(exp_pc) ? 32'd0 : memf(exp_pc));
                    fseen = is_fault(exp_pc);
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
            end
        end
        step();
        flush = 1'b0;
        out_ready = 1'b0;
        chk_eq("rnd.progress", {31'd0, pops >= 200}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
